// File: rtl/batch_streamer.sv
// Loads a batch of up to NUM items, then streams one CHANNELS*ITEM_WIDTH item per beat with a 1-cycle load-to-valid latency.
// The output holds its beat under out_ready_i backpressure. Define BATCH_STREAMER_STALL_CNT_EN to add the stall_cnt_o counter.
module batch_streamer #(
   parameter int NUM        = 100,
   parameter int CHANNELS   = 2,
   parameter int ITEM_WIDTH = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 load_valid_i,
   output logic                                 load_ready_o,
   input  logic [$clog2(NUM+1)-1:0]             load_count_i,
   input  logic [NUM*CHANNELS*ITEM_WIDTH-1:0]   load_data_i,
   input  logic                                 flush_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [CHANNELS*ITEM_WIDTH-1:0]       out_data_o,
   output logic                                 out_last_o,
   output logic                                 busy_o,
   output logic                                 done_o
`ifdef BATCH_STREAMER_STALL_CNT_EN
   ,output logic [31:0]                         stall_cnt_o
`endif
);

   localparam int CW = $clog2(NUM+1);
   localparam int IT = CHANNELS*ITEM_WIDTH;

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t          state;
   logic [NUM*IT-1:0] buffer;
   logic [CW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   load_cnt;
   logic [CW-1:0]   next_idx;
   logic [IT-1:0]   next_item;
   logic            load;
   logic            beat;

   assign load_ready_o = reset_i && (state == IDLE);
   assign load         = load_valid_i && load_ready_o;
   assign beat         = out_valid_o && out_ready_i;
   assign busy_o       = (state != IDLE);
   assign load_cnt     = (load_count_i > CW'(NUM)) ? CW'(NUM) : load_count_i;
   assign next_idx     = idx + CW'(1);

   always_comb begin
      next_item = '0;
      for (int i = 0; i < NUM; i++) begin
         if (next_idx == CW'(i)) next_item = buffer[i*IT +: IT];
      end
   end

   // Payload buffer carries no reset; only a load writes it.
   always_ff @(posedge clk_i) begin
      if (load) buffer <= load_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state       <= IDLE;
         out_valid_o <= 1'b0;
         out_last_o  <= 1'b0;
         out_data_o  <= '0;
         done_o      <= 1'b0;
         idx         <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  idx <= '0;
                  cnt <= load_cnt;
                  if (load_cnt != '0) begin
                     state       <= STREAM;
                     out_valid_o <= 1'b1;
                     out_data_o  <= load_data_i[IT-1:0];
                     out_last_o  <= (load_cnt == CW'(1));
                  end else begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            STREAM: begin
               // Flush wins over a last-beat transfer: the beat is taken, no done pulse.
               if (flush_i) begin
                  state       <= IDLE;
                  out_valid_o <= 1'b0;
                  out_last_o  <= 1'b0;
                  if (beat) idx <= next_idx;
               end else if (beat) begin
                  idx <= next_idx;
                  if (out_last_o) begin
                     state       <= DONE;
                     out_valid_o <= 1'b0;
                     out_last_o  <= 1'b0;
                     done_o      <= 1'b1;
                  end else begin
                     out_data_o <= next_item;
                     out_last_o <= (next_idx == cnt - CW'(1));
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               out_valid_o <= 1'b0;
               out_last_o  <= 1'b0;
               done_o      <= 1'b0;
            end
         endcase
      end
   end

`ifdef BATCH_STREAMER_STALL_CNT_EN
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         stall_cnt_o <= '0;
      end else if (load) begin
         stall_cnt_o <= '0;
      end else if (out_valid_o && !out_ready_i && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_batch_streamer.sv
// Bench for batch_streamer (NUM=4, CHANNELS=2, ITEM_WIDTH=8); checks stall_cnt_o when BATCH_STREAMER_STALL_CNT_EN is defined.
module tb_batch_streamer;
   localparam int NUM = 4;
   localparam int CH  = 2;
   localparam int IW  = 8;
   localparam int CW  = $clog2(NUM+1);

   logic                  clk = 1'b0;
   logic                  reset_i = 1'b0;
   logic                  load_valid_i = 1'b0;
   logic                  load_ready_o;
   logic [CW-1:0]         load_count_i = '0;
   logic [NUM*CH*IW-1:0]  load_data_i = '0;
   logic                  flush_i = 1'b0;
   logic                  out_valid_o;
   logic                  out_ready_i = 1'b0;
   logic [CH*IW-1:0]      out_data_o;
   logic                  out_last_o;
   logic                  busy_o;
   logic                  done_o;
`ifdef BATCH_STREAMER_STALL_CNT_EN
   logic [31:0]           stall_cnt_o;
`endif

   batch_streamer #(.NUM(NUM), .CHANNELS(CH), .ITEM_WIDTH(IW)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
      .load_count_i(load_count_i), .load_data_i(load_data_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o),
      .busy_o(busy_o), .done_o(done_o)
`ifdef BATCH_STREAMER_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dat;
      logic        last;
   } beat_t;

   typedef struct {
      logic [CW-1:0] cnt;
      logic [63:0]   data;
      int            stall_len;
      int            exp_stall;
      bit            flush_on_load;
      int            exp_beats;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vecs[6];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    beats_done = 0;
   int    done_cnt = 0;
   int    first_valid_cyc = -1;
   int    last_beat_cyc = -1;
   int    done_cyc = -1;
   bit    mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard consumer: every valid cycle is compared to the queue head, popped on transfer.
   always @(negedge clk) begin
      if (mon_en && reset_i === 1'b1) begin
         if (out_valid_o === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(out_valid_o), 64'd0);
            end else begin
               check("beat_data", 64'(out_data_o), 64'(exp_q[0].dat));
               check("beat_last", 64'(out_last_o), 64'(exp_q[0].last));
               if (out_ready_i === 1'b1) begin
                  if (out_last_o === 1'b1) last_beat_cyc = cyc;
                  void'(exp_q.pop_front());
                  beats_done++;
               end
            end
         end else begin
            check("last_without_valid", 64'(out_last_o), 64'd0);
         end
         if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_expected(input logic [63:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.dat  = data[16*i +: 16];
         b.last = (i == n-1);
         exp_q.push_back(b);
      end
   endtask

   task automatic run_batch(input vec_t v);
      int b0, d0, lc, stall_left, guard;
      check("load_ready_idle", 64'(load_ready_o), 64'd1);
      push_expected(v.data, v.exp_beats);
      b0 = beats_done; d0 = done_cnt;
      first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
      load_valid_i = 1'b1; load_count_i = v.cnt; load_data_i = v.data;
      flush_i = v.flush_on_load; out_ready_i = 1'b1;
      @(posedge clk); #1;
      lc = cyc;
      flush_i = 1'b0;
      // Offer a junk batch while busy; it must be ignored.
      load_count_i = CW'(3); load_data_i = ~v.data;
`ifdef BATCH_STREAMER_STALL_CNT_EN
      check("stall_cnt_clear_on_load", 64'(stall_cnt_o), 64'd0);
`endif
      stall_left = v.stall_len;
      guard = 0;
      while (done_cnt == d0 && guard < 50) begin
         out_ready_i = !((beats_done - b0 == 1) && stall_left > 0);
         if (!out_ready_i) stall_left--;
         @(posedge clk); #1;
         guard++;
      end
      load_valid_i = 1'b0;
      out_ready_i = 1'b1;
      check("done_seen", 64'(done_cnt != d0), 64'd1);
      check("beat_count", 64'(beats_done - b0), 64'(v.exp_beats));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      if (v.exp_beats > 0) begin
         check("first_valid_latency", 64'(first_valid_cyc), 64'(lc));
         check("last_beat_cycle", 64'(last_beat_cyc), 64'(lc + v.exp_beats - 1 + v.exp_stall));
         check("done_after_last", 64'(done_cyc), 64'(last_beat_cyc + 1));
      end else begin
         check("no_valid_on_empty", 64'(first_valid_cyc), 64'(-1));
         check("empty_done_cycle", 64'(done_cyc), 64'(lc));
      end
      check("ready_after_done", 64'(load_ready_o), 64'd1);
      check("done_one_cycle", 64'(done_o), 64'd0);
      check("busy_after_done", 64'(busy_o), 64'd0);
`ifdef BATCH_STREAMER_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt_o), 64'(v.exp_stall));
`endif
      @(posedge clk); #1;
      check("single_done", 64'(done_cnt - d0), 64'd1);
      exp_q.delete();
   endtask

   task automatic wait_beats(input int b0, input int target);
      int guard = 0;
      while (beats_done - b0 < target && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("reach_beat", 64'(beats_done - b0), 64'(target));
   endtask

   initial begin
      int b0, d0;
      vecs[0] = '{CW'(4), 64'h0807_0605_0403_0201, 0, 0, 1'b0, 4};
      vecs[1] = '{CW'(4), 64'h0807_0605_0403_0201, 3, 3, 1'b0, 4};
      vecs[2] = '{CW'(0), 64'h1111_2222_3333_4444, 0, 0, 1'b0, 0};
      vecs[3] = '{CW'(7), 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0, 4};
      vecs[4] = '{CW'(1), 64'h0000_0000_0000_A55A, 2, 0, 1'b1, 1};
      vecs[5] = '{CW'(2), 64'h1234_5678_9ABC_DEF0, 2, 2, 1'b0, 2};

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_last", 64'(out_last_o), 64'd0);
      check("rst_data", 64'(out_data_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_load_ready", 64'(load_ready_o), 64'd0);
      reset_i = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", 64'(load_ready_o), 64'd1);
      mon_en = 1'b1;

      for (int i = 0; i < 6; i++) run_batch(vecs[i]);

      // Flush while beat 2 transfers: beat counts as taken, no done pulse.
      push_expected(64'h0807_0605_0403_0201, 4);
      b0 = beats_done; d0 = done_cnt;
      load_valid_i = 1'b1; load_count_i = CW'(4); load_data_i = 64'h0807_0605_0403_0201; out_ready_i = 1'b1;
      @(posedge clk); #1;
      load_valid_i = 1'b0;
      wait_beats(b0, 1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_valid", 64'(out_valid_o), 64'd0);
      check("flush_busy", 64'(busy_o), 64'd0);
      check("flush_done", 64'(done_o), 64'd0);
      check("flush_beats_left", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("flush_no_done", 64'(done_cnt - d0), 64'd0);
      run_batch('{CW'(3), 64'h0000_0C0B_0A09_0807, 0, 0, 1'b0, 3});

      // Reset during beat 3 discards the batch.
      push_expected(64'h0807_0605_0403_0201, 4);
      b0 = beats_done; d0 = done_cnt;
      load_valid_i = 1'b1; load_count_i = CW'(4); load_data_i = 64'h0807_0605_0403_0201; out_ready_i = 1'b1;
      @(posedge clk); #1;
      load_valid_i = 1'b0;
      wait_beats(b0, 2);
      out_ready_i = 1'b0;
      reset_i = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", 64'(out_valid_o), 64'd0);
      check("mid_rst_last", 64'(out_last_o), 64'd0);
      check("mid_rst_data", 64'(out_data_o), 64'd0);
      check("mid_rst_done", 64'(done_o), 64'd0);
      check("mid_rst_busy", 64'(busy_o), 64'd0);
      check("mid_rst_load_ready", 64'(load_ready_o), 64'd0);
`ifdef BATCH_STREAMER_STALL_CNT_EN
      check("mid_rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
      reset_i = 1'b1;
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ready_after", 64'(load_ready_o), 64'd1);
      check("mid_rst_beats_left", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
      run_batch(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=cycle %0d required=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
